// File: rtl/adc_ad7175_emulator.sv
// AD7175-2 style SPI responder: decodes the comms byte, serves register reads/writes
// and drives DOUT/~RDY, all in the xclk domain by oversampling sclk/cs_n/sdi.
module adc_ad7175_emulator #(
  parameter logic [15:0] ID_VALUE    = 16'h0CD0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        xclk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_en,
  input  logic        sample_valid,
  input  logic [23:0] sample_data,
  output logic        rdy_n,
  output logic [15:0] adcmode,
  output logic [15:0] ifmode,
  output logic [15:0] ch0,
  output logic [15:0] setupcon0,
  output logic [15:0] filtcon0,
  output logic        reg_write_strobe,
  output logic [5:0]  reg_write_addr,
  output logic        data_read_strobe
);
  localparam logic [5:0] A_STATUS = 6'h00, A_ADCMODE = 6'h01, A_IFMODE = 6'h02,
                         A_DATA = 6'h04, A_ID = 6'h07, A_CH0 = 6'h10,
                         A_SETUP0 = 6'h20, A_FILT0 = 6'h28;

  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, sdi_sync_q;
  logic        sclk_s, cs_s, sdi_s, sclk_p_q, rise, fall;
  state_t      state_q;
  logic [6:0]  cmd_sh_q;
  logic [7:0]  cmd_byte;
  logic [5:0]  bit_cnt_q, len_q, addr_q, ones_q;
  logic [31:0] sh_q, load_w;
  logic [23:0] hold_q;
  logic [15:0] adcmode_q, ifmode_q, ch0_q, setup0_q, filt0_q, wr_val;
  logic        sdo_q, rdy_n_q, wr_stb_q, rd_stb_q, last;
  logic [5:0]  wr_addr_q;

  always_ff @(posedge xclk) begin
    if (!reset) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      sdi_sync_q  <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    end
  end

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign rise     = ~sclk_p_q & sclk_s;
  assign fall     = sclk_p_q & ~sclk_s;
  assign cmd_byte = {cmd_sh_q, sdi_s};
  assign last     = (bit_cnt_q == len_q - 6'd1);
  assign wr_val   = {sh_q[14:0], sdi_s};

  function automatic logic [5:0] len_of(input logic [5:0] a, input logic wide);
    case (a)
      A_ADCMODE, A_IFMODE, A_ID, A_CH0, A_SETUP0, A_FILT0: len_of = 6'd16;
      A_DATA:  len_of = wide ? 6'd32 : 6'd24;
      default: len_of = 6'd8;
    endcase
  endfunction

  // Read word is left-justified so RD always shifts out from bit 31.
  always_comb begin
    load_w = '0;
    case (cmd_byte[5:0])
      A_STATUS:  load_w = {rdy_n_q, 31'b0};
      A_ADCMODE: load_w = {adcmode_q, 16'b0};
      A_IFMODE:  load_w = {ifmode_q, 16'b0};
      A_DATA:    load_w = ifmode_q[6] ? {hold_q, rdy_n_q, 7'b0} : {hold_q, 8'b0};
      A_ID:      load_w = {ID_VALUE, 16'b0};
      A_CH0:     load_w = {ch0_q, 16'b0};
      A_SETUP0:  load_w = {setup0_q, 16'b0};
      A_FILT0:   load_w = {filt0_q, 16'b0};
      default:   load_w = '0;
    endcase
  end

  always_ff @(posedge xclk) begin
    if (!reset) begin
      state_q <= IDLE;  sclk_p_q <= 1'b1;  sdo_q <= 1'b1;  rdy_n_q <= 1'b1;
      cmd_sh_q <= '0;   bit_cnt_q <= '0;   len_q <= 6'd8;  addr_q <= '0;
      ones_q <= '0;     sh_q <= '0;        hold_q <= '0;
      wr_stb_q <= 1'b0; rd_stb_q <= 1'b0;  wr_addr_q <= '0;
      adcmode_q <= 16'h2000; ifmode_q <= 16'h0000; ch0_q <= 16'h8001;
      setup0_q  <= 16'h1000; filt0_q  <= 16'h0500;
    end else begin
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      sclk_p_q <= sclk_s;
      if (cs_s) begin
        state_q   <= IDLE;
        sdo_q     <= 1'b1;
        bit_cnt_q <= '0;
        ones_q    <= '0;
      end else begin
        if (rise) ones_q <= sdi_s ? ones_q + 6'd1 : 6'd0;
        case (state_q)
          IDLE: state_q <= CMD;
          CMD: begin
            sdo_q <= rdy_n_q;
            if (rise) begin
              cmd_sh_q  <= cmd_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 6'd1;
              if (bit_cnt_q == 6'd7) begin
                bit_cnt_q <= '0;
                if (!cmd_byte[7]) begin
                  addr_q <= cmd_byte[5:0];
                  len_q  <= len_of(cmd_byte[5:0], ifmode_q[6]);
                  if (cmd_byte[6]) begin
                    sh_q    <= load_w;
                    state_q <= RD;
                  end else begin
                    state_q <= WR;
                  end
                end
              end
            end
          end
          RD: begin
            if (fall) begin
              sdo_q <= sh_q[31];
              sh_q  <= {sh_q[30:0], 1'b0};
            end
            if (rise) begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
              if (last) begin
                bit_cnt_q <= '0;
                state_q   <= CMD;
                if (addr_q == A_DATA) begin
                  rdy_n_q  <= 1'b1;
                  rd_stb_q <= 1'b1;
                end
              end
            end
          end
          WR: begin
            if (rise) begin
              sh_q      <= {sh_q[30:0], sdi_s};
              bit_cnt_q <= bit_cnt_q + 6'd1;
              if (last) begin
                bit_cnt_q <= '0;
                state_q   <= CMD;
                wr_stb_q  <= 1'b1;
                wr_addr_q <= addr_q;
                case (addr_q)
                  A_ADCMODE: adcmode_q <= wr_val;
                  A_IFMODE:  ifmode_q  <= wr_val;
                  A_CH0:     ch0_q     <= wr_val;
                  A_SETUP0:  setup0_q  <= wr_val;
                  A_FILT0:   filt0_q   <= wr_val;
                  default: begin
                    wr_stb_q  <= 1'b0;
                    wr_addr_q <= wr_addr_q;
                  end
                endcase
              end
            end
          end
          default: state_q <= IDLE;
        endcase
        // 64 consecutive ones: interface reset, overriding whatever this bit did above.
        if (rise && sdi_s && ones_q == 6'd63) begin
          state_q <= CMD;   bit_cnt_q <= '0;  ones_q <= '0;  rdy_n_q <= 1'b1;
          hold_q <= '0;     wr_stb_q <= 1'b0; rd_stb_q <= 1'b0; wr_addr_q <= '0;
          adcmode_q <= 16'h2000; ifmode_q <= 16'h0000; ch0_q <= 16'h8001;
          setup0_q  <= 16'h1000; filt0_q  <= 16'h0500;
        end
      end
      if (sample_valid) begin
        hold_q  <= sample_data;
        rdy_n_q <= 1'b0;
      end
    end
  end

  assign sdo              = sdo_q;
  assign sdo_en           = ~cs_s;
  assign rdy_n            = rdy_n_q;
  assign adcmode          = adcmode_q;
  assign ifmode           = ifmode_q;
  assign ch0              = ch0_q;
  assign setupcon0        = setup0_q;
  assign filtcon0         = filt0_q;
  assign reg_write_strobe = wr_stb_q;
  assign reg_write_addr   = wr_addr_q;
  assign data_read_strobe = rd_stb_q;
endmodule

// File: tb/tb_adc_ad7175_emulator.sv
// Directed bench: a small SPI master drives transfers, each task checks its own results.
`timescale 1ns/1ps
module tb_adc_ad7175_emulator;
  localparam int HALF = 60;

  logic        xclk = 0, reset = 0, sclk = 1, cs_n = 1, sdi = 0;
  logic        sample_valid = 0;
  logic [23:0] sample_data = '0;
  logic        sdo, sdo_en, rdy_n, reg_write_strobe, data_read_strobe;
  logic [15:0] adcmode, ifmode, ch0, setupcon0, filtcon0;
  logic [5:0]  reg_write_addr;
  int vecs = 0, errs = 0, wr_cnt = 0, dr_cnt = 0;

  adc_ad7175_emulator #(.ID_VALUE(16'h0CD0), .SYNC_STAGES(2)) dut (
    .xclk(xclk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .sdi(sdi),
    .sdo(sdo), .sdo_en(sdo_en), .sample_valid(sample_valid), .sample_data(sample_data),
    .rdy_n(rdy_n), .adcmode(adcmode), .ifmode(ifmode), .ch0(ch0),
    .setupcon0(setupcon0), .filtcon0(filtcon0), .reg_write_strobe(reg_write_strobe),
    .reg_write_addr(reg_write_addr), .data_read_strobe(data_read_strobe));

  always #5 xclk = ~xclk;

  always @(negedge xclk) begin
    if (reg_write_strobe) wr_cnt++;
    if (data_read_strobe) dr_cnt++;
  end

  task automatic shift_bits(input logic [31:0] out, input int n, output logic [31:0] in);
    in = '0;
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 0; sdi = out[i]; #HALF;
      sclk = 1; in = {in[30:0], sdo}; #HALF;
    end
  endtask

  task automatic cs_low();
    @(posedge xclk); #2; cs_n = 0; #80;
  endtask

  task automatic cs_high();
    #40; cs_n = 1; #100;
  endtask

  task automatic xfer(input logic [7:0] cmd, input int n, input logic [31:0] wd,
                      output logic [31:0] rd);
    logic [31:0] dummy;
    cs_low();
    shift_bits({24'b0, cmd}, 8, dummy);
    shift_bits(wd, n, rd);
    cs_high();
  endtask

  task automatic pulse_sample(input logic [23:0] d);
    @(posedge xclk); #2; sample_valid = 1; sample_data = d;
    @(posedge xclk); #2; sample_valid = 0;
  endtask

  task automatic test_reset();
    reset = 0; repeat (4) @(posedge xclk); #2;
    vecs++; if (sdo !== 1'b1 || sdo_en !== 1'b0 || rdy_n !== 1'b1) begin errs++;
      $display("FAIL reset_pins got sdo=%b en=%b rdy_n=%b want 1 0 1", sdo, sdo_en, rdy_n); end
    vecs++; if (reg_write_strobe !== 1'b0 || data_read_strobe !== 1'b0 || reg_write_addr !== 6'h00) begin errs++;
      $display("FAIL reset_strobes got %b %b %h want 0 0 00", reg_write_strobe, data_read_strobe, reg_write_addr); end
    vecs++; if ({adcmode, ifmode, ch0, setupcon0, filtcon0} !== {16'h2000, 16'h0000, 16'h8001, 16'h1000, 16'h0500}) begin errs++;
      $display("FAIL reset_regs got %h %h %h %h %h want 2000 0000 8001 1000 0500", adcmode, ifmode, ch0, setupcon0, filtcon0); end
    reset = 1; repeat (4) @(posedge xclk);
  endtask

  task automatic test_id_read();
    logic [31:0] rd, dummy; int w0, d0;
    w0 = wr_cnt; d0 = dr_cnt;
    cs_low();
    vecs++; if (sdo_en !== 1'b1) begin errs++; $display("FAIL id_sdo_en_low got %b want 1", sdo_en); end
    shift_bits(32'h47, 8, dummy);
    shift_bits('0, 16, rd);
    cs_high();
    vecs++; if (rd[15:0] !== 16'h0CD0) begin errs++; $display("FAIL id_read got %h want 0cd0", rd[15:0]); end
    vecs++; if (sdo_en !== 1'b0) begin errs++; $display("FAIL id_sdo_en_high got %b want 0", sdo_en); end
    vecs++; if (wr_cnt != w0 || dr_cnt != d0) begin errs++;
      $display("FAIL id_no_strobes got wr+%0d dr+%0d want 0 0", wr_cnt - w0, dr_cnt - d0); end
  endtask

  task automatic test_status_read();
    logic [31:0] rd;
    xfer(8'h40, 8, '0, rd);
    vecs++; if (rd !== 32'h80) begin errs++; $display("FAIL status_read got %h want 00000080", rd); end
  endtask

  task automatic test_write_adcmode();
    logic [31:0] rd; int w0;
    w0 = wr_cnt;
    xfer(8'h01, 16, 32'h8010, rd);
    vecs++; if (adcmode !== 16'h8010) begin errs++; $display("FAIL adcmode_write got %h want 8010", adcmode); end
    vecs++; if (wr_cnt != w0 + 1 || reg_write_addr !== 6'h01) begin errs++;
      $display("FAIL adcmode_strobe got cnt+%0d addr=%h want 1 01", wr_cnt - w0, reg_write_addr); end
    xfer(8'h41, 16, '0, rd);
    vecs++; if (rd !== 32'h8010) begin errs++; $display("FAIL adcmode_readback got %h want 00008010", rd); end
  endtask

  task automatic test_data_read();
    logic [31:0] rd, dummy; int d0, k;
    d0 = dr_cnt;
    cs_low();
    vecs++; if (sdo !== 1'b1) begin errs++; $display("FAIL ready_idle got sdo=%b want 1", sdo); end
    pulse_sample(24'hA5C3F0);
    k = 0;
    while (sdo !== 1'b0 && k < 50) begin @(negedge xclk); k++; end
    vecs++; if (sdo !== 1'b0) begin errs++; $display("FAIL ready_wait got sdo=%b want 0 (timeout)", sdo); end
    #3;
    shift_bits(32'h44, 8, dummy);
    shift_bits('0, 24, rd);
    cs_high();
    vecs++; if (rd !== 32'h00A5C3F0) begin errs++; $display("FAIL data24 got %h want 00a5c3f0", rd); end
    vecs++; if (rdy_n !== 1'b1 || dr_cnt != d0 + 1) begin errs++;
      $display("FAIL data24_done got rdy_n=%b strobes=%0d want 1 1", rdy_n, dr_cnt - d0); end
  endtask

  task automatic test_data32();
    logic [31:0] rd;
    xfer(8'h02, 16, 32'h0040, rd);
    vecs++; if (ifmode !== 16'h0040) begin errs++; $display("FAIL ifmode_write got %h want 0040", ifmode); end
    pulse_sample(24'h123456);
    vecs++; if (rdy_n !== 1'b0) begin errs++; $display("FAIL rdy_after_sample got %b want 0", rdy_n); end
    xfer(8'h44, 32, '0, rd);
    vecs++; if (rd !== 32'h12345600) begin errs++; $display("FAIL data32_first got %h want 12345600", rd); end
    xfer(8'h44, 32, '0, rd);
    vecs++; if (rd !== 32'h12345680) begin errs++; $display("FAIL data32_second got %h want 12345680", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd, dummy; int w0;
    w0 = wr_cnt;
    cs_low();
    shift_bits(32'h10, 8, dummy);
    shift_bits(32'h0555, 12, dummy);
    cs_high();
    vecs++; if (ch0 !== 16'h8001 || wr_cnt != w0) begin errs++;
      $display("FAIL abort_write got ch0=%h strobes=%0d want 8001 0", ch0, wr_cnt - w0); end
    xfer(8'h50, 16, '0, rd);
    vecs++; if (rd !== 32'h8001) begin errs++; $display("FAIL abort_next_read got %h want 00008001", rd); end
  endtask

  task automatic test_iface_reset();
    logic [31:0] rd, dummy;
    xfer(8'h28, 16, 32'h0000, rd);
    vecs++; if (filtcon0 !== 16'h0000) begin errs++; $display("FAIL filt_write got %h want 0000", filtcon0); end
    pulse_sample(24'h00BEEF);
    cs_low();
    shift_bits('1, 32, dummy);
    shift_bits('1, 32, dummy);
    cs_high();
    vecs++; if (filtcon0 !== 16'h0500 || rdy_n !== 1'b1 || ifmode !== 16'h0000) begin errs++;
      $display("FAIL iface_reset got filt=%h rdy_n=%b ifmode=%h want 0500 1 0000", filtcon0, rdy_n, ifmode); end
    xfer(8'h47, 16, '0, rd);
    vecs++; if (rd !== 32'h0CD0) begin errs++; $display("FAIL iface_reset_id got %h want 00000cd0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, dummy;
    xfer(8'h20, 16, 32'h1234, rd);
    vecs++; if (setupcon0 !== 16'h1234) begin errs++; $display("FAIL setup_write got %h want 1234", setupcon0); end
    cs_low();
    shift_bits(32'h01, 8, dummy);
    shift_bits(32'h0F, 6, dummy);
    @(posedge xclk); #2; reset = 0;
    @(posedge xclk); #2; reset = 1;
    vecs++; if (setupcon0 !== 16'h1000 || sdo !== 1'b1 || rdy_n !== 1'b1) begin errs++;
      $display("FAIL reset_mid got setup=%h sdo=%b rdy_n=%b want 1000 1 1", setupcon0, sdo, rdy_n); end
    cs_high();
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_status_read();
    test_write_adcmode();
    test_data_read();
    test_data32();
    test_abort();
    test_iface_reset();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/adc_ad7175_emulator.md
Name: adc_ad7175_emulator

Overview:
- SPI responder that emulates the AD7175-2 serial interface, as seen by the team's existing AD7175 comms master.
- Lets one FPGA stand in for the ADC on loop-back or self-test boards: decodes the 8-bit communications byte, serves register reads and writes, and signals DOUT/~RDY.
- Conversion samples come from local fabric; writable configuration registers are exported to fabric.
- Runs entirely in the xclk domain, oversampling sclk, cs_n and sdi.

Parameters:
- ID_VALUE, 16'h0CD0, value returned for ID register (addr 0x07).
- SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/sdi (minimum 2).

Ports:
- xclk  in  1  system clock.
- reset  in  1  synchronous, active-low; one clock; sampled on posedge xclk.
- sclk  in  1  serial clock from master; idles HI; period ≥ 8 xclk.
- cs_n  in  1  chip select from master, active LOW.
- sdi  in  1  master data out; sampled on sclk rising edge.
- sdo  out  1  DOUT/~RDY to master; changes after sclk falling edge.
- sdo_en  out  1  HI while synchronized cs_n is LOW (pad tristate control).
- sample_valid  in  1  one-xclk strobe: new conversion result.
- sample_data  in  24  conversion result, latched on sample_valid.
- rdy_n  out  1  current ~RDY flag.
- adcmode, ifmode, ch0, setupcon0, filtcon0  out  16 each  register contents.
- reg_write_strobe  out  1  one-xclk pulse when a register write completes.
- reg_write_addr  out  6  address of the completed write.
- data_read_strobe  out  1  one-xclk pulse when a DATA register read completes.

Behaviour:
Reset values:
- sdo=1, sdo_en=0, rdy_n=1, strobes=0, reg_write_addr=0, data holding reg=0.
- adcmode=16'h2000, ifmode=0, ch0=16'h8001, setupcon0=16'h1000, filtcon0=16'h0500.
- FSM=IDLE, bit counter=0, ones counter=0.

Edge detection:
- Edges are detected on the synchronized sclk: rise = prev 0 / now 1; fall = prev 1 / now 0.
- sdi is sampled with the same sync depth on rise.
- sdo is registered and updates exactly SYNC_STAGES+1 xclk after the physical sclk falling edge.

FSM:
- IDLE: synchronized cs_n HI; sdo=1; counters cleared. cs_n LOW -> CMD.
- CMD: shift 8 sdi bits MSB first on rise. After bit 8:
  - bit7 (WEN)=1: byte discarded, stay in CMD.
  - else latch R/W=bit6 and addr=bits5:0; length L = 16 for 0x01, 0x02, 0x07, 0x10, 0x20, 0x28; L = 24 for 0x04; L = 32 for 0x04 when ifmode[6]=1; L = 8 for 0x00 and for unmapped addresses.
  - Read -> RD (shift reg loaded in the same cycle as bit-8 rise). Write -> WR.
- RD: on each fall, sdo = shift MSB, then shift left.
  - DATA reg: 24-bit holding value; for L=32, the status byte {rdy_n at load, 5'b0, 2'b00} is appended LSB-side.
  - STATUS: {rdy_n, 7'b0}. Unmapped: 8'h00.
  - After the L-th rise -> CMD.
  - For DATA: rdy_n<=1 and data_read_strobe pulses on that cycle.
- WR: shift L bits of sdi. On the L-th rise, update the register and pulse reg_write_strobe with reg_write_addr=addr. Writes to 0x00, 0x04, 0x07 and unmapped addresses are discarded, with no strobe. Then -> CMD.
- While in CMD, sdo=rdy_n (DOUT/~RDY indication) and is updated every xclk.

~RDY:
- sample_valid: holding reg <= sample_data, rdy_n<=0.
- Shift-register contents already loaded are unaffected by a later sample.
- sample_valid on the same cycle as a DATA read completion: set wins, rdy_n=0.

Abort:
- cs_n HI in any state -> IDLE next xclk.
- Partial write discarded, no strobe; rdy_n unchanged.

Interface reset:
- 64 consecutive 1s sampled on sdi (any state, cs_n LOW) -> all registers and rdy_n return to reset values, FSM -> CMD, ones counter cleared.
- Any 0 bit clears the ones counter.

Reset:
- reset LOW mid-transfer restores all reset values on the next posedge xclk, regardless of sclk/cs_n.

Test Plan:
- Master reads ID (comms 8'h47, 16-bit) -> data_read bits[15:0]=16'h0CD0; no strobes; sdo_en HI only during cs_n LOW.
- Master writes ADCMODE (comms 8'h01, data 16'h8010) -> adcmode=16'h8010, one reg_write_strobe with reg_write_addr=6'h01; readback via 8'h41 returns 16'h8010.
- sample_valid with sample_data=24'hA5C3F0; master uses wait_for_ready=1 and reads 8'h44, 24-bit -> master sees sdo HI->LOW, reads 24'hA5C3F0; rdy_n returns 1; data_read_strobe pulses once.
- Write ifmode=16'h0040, sample 24'h123456, read 8'h44 with 32-bit length -> 32'h12345600 (status bit7=0); second read without a new sample -> 32'h12345680.
- Master starts a write of 16'h5555 to 8'h10 and raises cs_n after 12 bits -> ch0 stays 16'h8001, no strobe; next transfer decodes a fresh comms byte correctly.
- 64 ones on sdi after writing filtcon0=16'h0000 -> filtcon0=16'h0500, rdy_n=1; next comms 8'h47 reads 16'h0CD0.
